// File: rtl/rv32_pkg.sv
// Shared RV32 fetch-stage constants: address width, reset vector, PC step
// and the encoding of the next-PC select.
package rv32_pkg;

    localparam int unsigned      XLEN         = 32;
    localparam logic [XLEN-1:0]  RESET_VECTOR = 32'h0000_0000;
    localparam int unsigned      PC_INCR      = 4;

    // Next-PC select encoding
    localparam logic PC_SEL_SEQ = 1'b0;
    localparam logic PC_SEL_ALU = 1'b1;

    typedef logic [XLEN-1:0] addr_t;

endpackage : rv32_pkg

// File: rtl/rv32_pc_unit_mux2.sv
// XLEN-wide 2:1 next-PC select, shared with other stages that pick
// between a sequential and a redirect address.
module pc_mux2 #(
    parameter int unsigned W = rv32_pkg::XLEN
) (
    input  logic         sel_i,
    input  logic [W-1:0] seq_i,
    input  logic [W-1:0] alu_i,
    output logic [W-1:0] y_o
);
    import rv32_pkg::*;

    // Choose the redirect target when selected, otherwise the sequential address
    always_comb begin
        y_o = seq_i;
        if (sel_i == PC_SEL_ALU) begin
            y_o = alu_i;
        end
    end

endmodule : pc_mux2

// File: rtl/rv32_pc_unit.sv
// Program-counter register for the RV32 fetch stage. Loads either the
// sequential address or an ALU redirect target each clock and exposes the
// combinational successor pc + PC_INCR. Targets are loaded verbatim; any
// LSB masking for JALR happens upstream.
module rv32_pc_unit #(
    parameter int unsigned                  XLEN         = rv32_pkg::XLEN,
    parameter logic [XLEN-1:0]              RESET_VECTOR = rv32_pkg::RESET_VECTOR,
    parameter int unsigned                  PC_INCR      = rv32_pkg::PC_INCR
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            sel_pc,
    input  logic [XLEN-1:0] in_pc,
    input  logic [XLEN-1:0] in_alu,
    output logic [XLEN-1:0] pc_nxt,
    output logic [XLEN-1:0] pc
);
    import rv32_pkg::*;

    logic [XLEN-1:0] pc_q;
    logic [XLEN-1:0] pc_d;

    pc_mux2 #(
        .W (XLEN)
    ) u_mux (
        .sel_i (sel_pc),
        .seq_i (in_pc),
        .alu_i (in_alu),
        .y_o   (pc_d)
    );

    // PC register: synchronous reset has priority over any load
    always_ff @(posedge clk) begin
        if (rst) begin
            pc_q <= RESET_VECTOR;
        end else begin
            pc_q <= pc_d;
        end
    end

    // Sequential successor wraps modulo 2^XLEN with no overflow indication
    always_comb begin
        pc_nxt = pc_q + XLEN'(PC_INCR);
    end

    assign pc = pc_q;

endmodule : rv32_pc_unit

// File: tb/tb_rv32_pc_unit.sv
// Randomized self-checking bench for rv32_pc_unit against a small
// behavioural model of the program counter.
module tb_rv32_pc_unit;

    logic        clk;
    logic        rst;
    logic        sel_pc;
    logic [31:0] in_pc;
    logic [31:0] in_alu;
    logic [31:0] pc_nxt;
    logic [31:0] pc;

    // Feedback control: when tie is set, in_pc follows pc_nxt as at top level
    logic        tie;
    logic [31:0] in_pc_rnd;

    logic [31:0] exp_pc;
    int          n_chk;
    int          n_err;

    assign in_pc = tie ? pc_nxt : in_pc_rnd;

    rv32_pc_unit dut (
        .clk    (clk),
        .rst    (rst),
        .sel_pc (sel_pc),
        .in_pc  (in_pc),
        .in_alu (in_alu),
        .pc_nxt (pc_nxt),
        .pc     (pc)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
        n_chk++;
        if (obs !== exp_v) begin
            n_err++;
            $display("FAIL %s got=%h expected=%h", tag, obs, exp_v);
        end
    endtask

    // Apply one cycle of inputs, advance the model at the edge, check at negedge
    task automatic step(input bit r, input bit s, input logic [31:0] alu,
                        input bit t, input logic [31:0] rn, input string tag);
        rst       = r;
        sel_pc    = s;
        in_alu    = alu;
        tie       = t;
        in_pc_rnd = rn;
        @(posedge clk);
        if (r)      exp_pc = 32'h0000_0000;
        else if (s) exp_pc = alu;
        else if (t) exp_pc = exp_pc + 32'd4;
        else        exp_pc = rn;
        @(negedge clk);
        check({tag, "_pc"},  pc,     exp_pc);
        check({tag, "_nxt"}, pc_nxt, exp_pc + 32'd4);
    endtask

    initial begin
        n_chk     = 0;
        n_err     = 0;
        rst       = 1'b1;
        sel_pc    = 1'b0;
        in_alu    = 32'h0;
        tie       = 1'b1;
        in_pc_rnd = 32'h0;
        exp_pc    = 32'h0;

        @(negedge clk);
        // Reset with feedback tied
        step(1, 0, 32'h0, 1, 32'h0, "reset");
        check("reset_pc_abs",  pc,     32'h0000_0000);
        check("reset_nxt_abs", pc_nxt, 32'h0000_0004);

        // Sequential run 4..0x14
        for (int i = 0; i < 5; i++) step(0, 0, 32'h0, 1, 32'h0, "seq");
        check("seq_pc_abs", pc, 32'h0000_0014);

        // Redirect then continue sequentially
        step(0, 1, 32'h0000_8000, 1, 32'h0, "redir");
        check("redir_pc_abs", pc, 32'h0000_8000);
        step(0, 0, 32'h0, 1, 32'h0, "redir_seq");
        step(0, 0, 32'h0, 1, 32'h0, "redir_seq");
        check("redir_seq_abs", pc, 32'h0000_8008);

        // Reset wins over redirect
        step(1, 1, 32'h0000_8000, 1, 32'h0, "rst_prio");
        check("rst_prio_abs", pc, 32'h0000_0000);
        step(0, 0, 32'h0, 1, 32'h0, "resume");

        // Reset pulse confined between edges must be ignored
        rst = 1'b1;
        #2;
        rst = 1'b0;
        step(0, 0, 32'h0, 1, 32'h0, "pulse");
        check("pulse_abs", pc, 32'h0000_0008);

        // Misaligned target loads verbatim
        step(0, 1, 32'h0000_1003, 1, 32'h0, "misalign");
        check("misalign_abs", pc, 32'h0000_1003);

        // Wrap-around
        step(0, 1, 32'hFFFF_FFFC, 1, 32'h0, "wrap");
        check("wrap_nxt_abs", pc_nxt, 32'h0000_0000);
        step(0, 0, 32'h0, 1, 32'h0, "wrap_seq");
        check("wrap_seq_abs", pc, 32'h0000_0000);

        // Randomized mix of reset, redirects, feedback and free sequential loads
        for (int i = 0; i < 400; i++) begin
            bit          r;
            bit          s;
            bit          t;
            logic [31:0] a;
            logic [31:0] rn;
            r  = ($urandom_range(0, 15) == 0);
            s  = ($urandom_range(0, 3) == 0);
            t  = ($urandom_range(0, 3) != 0);
            a  = $urandom;
            rn = $urandom;
            step(r, s, a, t, rn, "rand");
        end

        $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
        $finish;
    end

    // Safety net against an unexpected stall of the stimulus process
    initial begin
        #200000;
        $display("FAIL timeout got=running expected=finished");
        $fatal(1, "timeout");
    end

endmodule : tb_rv32_pc_unit

// File: doc/rv32_pc_unit.md
Name: rv32_pc_unit

Overview:
- Program-counter register for the RV32 pipeline fetch stage.
- Holds the current instruction address `pc` and produces the sequential successor `pc_nxt` (pc + 4).
- Each clock it loads either the sequential address (`in_pc`) or a redirect target computed by the ALU (`in_alu`), selected by `sel_pc`.
- At the top level, `pc_nxt` is normally wired back into `in_pc`.

Parameters:
- XLEN, 32, address/data width in bits.
- RESET_VECTOR, 32'h0000_0000, value loaded into `pc` on reset.
- PC_INCR, 4, constant added to `pc` to form `pc_nxt`.

Ports:
- clk  input  1  system clock; all state updates on the rising edge.
- rst  input  1  synchronous, active-high reset.
- sel_pc  input  1  next-PC select: 0 = `in_pc` (sequential), 1 = `in_alu` (branch/jump target).
- in_pc  input  XLEN  sequential next address, normally driven from `pc_nxt`.
- in_alu  input  XLEN  redirect target from the ALU (branch/JAL/JALR result).
- pc_nxt  output  XLEN  combinational `pc + PC_INCR`.
- pc  output  XLEN  registered current program counter.

Behaviour:
- One clock (`clk`); reset `rst` is synchronous and active-high. Reset is sampled only on the rising edge of `clk`; no asynchronous path.
- Reset:
  - On a rising edge with rst=1, `pc` <= RESET_VECTOR.
  - This takes priority over `sel_pc`, `in_pc` and `in_alu`.
  - Reset values: `pc` = 0x0000_0000, hence `pc_nxt` = 0x0000_0004.
  - Before the first reset edge, `pc` is undefined (X in simulation); no initial value is required.
- Normal update, on a rising edge with rst=0:
  - sel_pc=0: `pc` <= `in_pc`.
  - sel_pc=1: `pc` <= `in_alu`.
  - Latency is one cycle from select/input to visible `pc`.
- Load values: `in_alu` and `in_pc` are loaded verbatim.
  - No bit-0 clearing and no alignment check; JALR LSB masking is done upstream.
  - Misaligned targets propagate unchanged.
- pc_nxt:
  - Purely combinational: `pc_nxt` = (`pc` + PC_INCR) mod 2^XLEN.
  - Changes in the same cycle `pc` changes.
  - Wrap-around: `pc` = 0xFFFF_FFFC gives `pc_nxt` = 0x0000_0000; no overflow flag.
- Sequential feedback: with `in_pc` tied to `pc_nxt` and sel_pc=0, `pc` advances 0, 4, 8, 12, … one step per clock.
- Simultaneous events:
  - rst=1 together with sel_pc=1: reset wins.
  - Reset asserted mid-run returns `pc` to RESET_VECTOR on the next edge.
  - Sequencing resumes on the first edge after rst deasserts.
- No combinational path from any input to `pc`. The only combinational output path is `pc` → `pc_nxt`.

Decomposition:
- Shared package (rv32_pkg): XLEN, RESET_VECTOR, PC_INCR, and a PC_SEL_SEQ=1'b0 / PC_SEL_ALU=1'b1 encoding for `sel_pc`.
- A single flat module is sufficient.
- An optional sub-module `pc_mux2` (XLEN-wide 2:1 select) may be factored out for reuse by other stages.

Test Plan:
- Reset:
  - Stimulus: rst=1 over ≥1 rising edge, sel_pc=0, `in_pc`=`pc_nxt`.
  - Required: `pc`=0x0 and `pc_nxt`=0x4 on the edge after rst asserts.
- Sequential run:
  - Stimulus: deassert rst, sel_pc=0, `in_pc`=`pc_nxt` for 5 cycles.
  - Required: `pc` = 0x4, 0x8, 0xC, 0x10, 0x14; `pc_nxt` always `pc`+4.
- Redirect:
  - Stimulus: sel_pc=1, `in_alu`=0x0000_8000 for one edge, then sel_pc=0.
  - Required: `pc`=0x8000, then 0x8004, 0x8008.
- Reset priority:
  - Stimulus: rst=1 and sel_pc=1 with `in_alu`=0x8000 at the same edge.
  - Required: `pc`=0x0, not 0x8000.
- Synchronous reset check:
  - Stimulus: pulse rst high between two rising edges, low again before the next edge.
  - Required: `pc` unchanged (continues incrementing); reset has no effect without an edge.
- Wrap-around:
  - Stimulus: sel_pc=1, `in_alu`=0xFFFF_FFFC, then sel_pc=0.
  - Required: `pc_nxt`=0x0 while `pc`=0xFFFF_FFFC; `pc`=0x0 on the following edge.
